fnd_scan_ctrl: RTL

Scan and update controller for the 4-digit FND datapath. It accepts a 16-bit binary display value through a valid/ready handshake and converts it to four BCD digits with a sequential double-dabble engine. The new value is committed to the display only at frame boundaries. It sequences digit scanning with a per-slot blanking interval for anti-ghosting and optional leading-zero suppression. It sits between the APB FND register and the BCD-to-segment decoder.

---
 rtl/fnd_scan_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fnd_scan_ctrl.sv
// 4-digit FND scan controller: valid/ready update, sequential double-dabble
// conversion, frame-boundary commit, per-slot blanking and leading-zero blanking.
module fnd_scan_ctrl #(
   parameter int TICK_DIV    = 100000,
   parameter int BLANK_CYC   = 1000,
   parameter int LZ_SUPPRESS = 1
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        upd_valid,
   input  logic [15:0] upd_data,
   output logic        upd_ready,
   output logic        ovf,
   output logic [1:0]  digit_sel,
   output logic [3:0]  digit_val,
   output logic        digit_en,
   output logic [3:0]  fnd_com,
   output logic        frame_done
);

   // state    | meaning
   // ST_IDLE  | waiting for a value; ready when nothing is pending
   // ST_SHIFT | 16 add-3/shift iterations of the binary value
   // ST_DONE  | hand converted BCD to the pending register
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [1:0]    digit_sel_q, digit_sel_d;
   logic [15:0]   act_bcd_q, act_bcd_d;
   logic [15:0]   pend_bcd_q, pend_bcd_d;
   logic          pend_vld_q, pend_vld_d;
   logic [1:0]    state_q, state_d;
   logic [15:0]   bin_q, bin_d;
   logic [15:0]   bcd_q, bcd_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          frame_done_q, frame_done_d;

   logic          wrap;
   logic [15:0]   adj;
   logic          suppressed;

   assign wrap = (tick_cnt_q == TW'(TICK_DIV - 1));

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      tick_cnt_d   = wrap ? '0 : tick_cnt_q + 1'b1;
      digit_sel_d  = wrap ? digit_sel_q + 2'd1 : digit_sel_q;
      frame_done_d = wrap && (digit_sel_q == 2'd3);
      act_bcd_d    = act_bcd_q;
      pend_bcd_d   = pend_bcd_q;
      pend_vld_d   = pend_vld_q;
      state_d      = state_q;
      bin_d        = bin_q;
      bcd_d        = bcd_q;
      cnt_d        = cnt_q;
      ovf_d        = ovf_q;

      // Commit looks at the old pending flag, so a DONE on the boundary waits a frame.
      if (frame_done_d && pend_vld_q) begin
         act_bcd_d  = pend_bcd_q;
         pend_vld_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (upd_valid && upd_ready) begin
               ovf_d   = (upd_data > 16'd9999);
               bin_d   = ovf_d ? 16'd9999 : upd_data;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            bcd_d = {adj[14:0], bin_q[15]};
            bin_d = {bin_q[14:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) state_d = ST_DONE;
         end
         ST_DONE: begin
            pend_bcd_d = bcd_q;
            pend_vld_d = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         tick_cnt_q   <= '0;
         digit_sel_q  <= '0;
         act_bcd_q    <= '0;
         pend_bcd_q   <= '0;
         pend_vld_q   <= 1'b0;
         state_q      <= ST_IDLE;
         bin_q        <= '0;
         bcd_q        <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         digit_sel_q  <= digit_sel_d;
         act_bcd_q    <= act_bcd_d;
         pend_bcd_q   <= pend_bcd_d;
         pend_vld_q   <= pend_vld_d;
         state_q      <= state_d;
         bin_q        <= bin_d;
         bcd_q        <= bcd_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         frame_done_q <= frame_done_d;
      end
   end

   // A slot above the ones digit is blank when it and every higher digit are zero.
   assign suppressed = (LZ_SUPPRESS != 0) && (digit_sel_q != 2'd0) &&
                       ((act_bcd_q >> {digit_sel_q, 2'b00}) == 16'd0);

   assign upd_ready  = (state_q == ST_IDLE) && !pend_vld_q;
   assign ovf        = ovf_q;
   assign digit_sel  = digit_sel_q;
   assign digit_val  = act_bcd_q[{digit_sel_q, 2'b00} +: 4];
   assign digit_en   = (tick_cnt_q >= TW'(BLANK_CYC)) && !suppressed;
   assign fnd_com    = digit_en ? ~(4'b0001 << digit_sel_q) : 4'b1111;
   assign frame_done = frame_done_q;

endmodule
